// File: rtl/ps2_scan_rx.sv
// PS/2 device-to-host frame receiver with make/break key tracking.
// Presents the currently and previously held make codes to sound_ctrl.
module ps2_scan_rx #(
    parameter int unsigned FILT_LEN    = 8,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan,
    output logic [7:0] prevscan,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int unsigned FW = $clog2(FILT_LEN + 1);
    localparam int unsigned WW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    // Synchronizers idle high, like the open-collector lines they sample
    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          level_q, level_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall;

    state_e        state_q, state_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          timeout;
    logic [7:0]    rx_byte_d;
    logic          rx_valid_d, frame_err_d;

    logic [7:0]    scan_d, prev_d;
    logic          ext_q, ext_d, brk_q, brk_d;

    // Two-flop synchronizers for both pins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Glitch filter: level follows ps2_clk only after FILT_LEN stable differing cycles
    always_comb begin
        level_d = level_q;
        fcnt_d  = '0;
        if (clk_s2_q != level_q) begin
            if (fcnt_q == FW'(FILT_LEN - 1)) begin
                level_d = clk_s2_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
    end

    assign fall    = level_q & ~level_d;
    assign timeout = (state_q != StIdle) && !fall && (wdog_q >= WW'(TIMEOUT_CYC - 1));

    // Frame FSM next-state, watchdog and receive pulses
    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        rx_byte_d   = rx_byte;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        wdog_d      = (fall || state_q == StIdle) ? '0 : wdog_q + WW'(1);
        if (timeout) begin
            // Partial byte is dropped; shift_q is overwritten by the next frame
            frame_err_d = 1'b1;
            state_d     = StIdle;
            wdog_d      = '0;
        end else if (fall) begin
            unique case (state_q)
                StIdle: begin
                    if (!dat_s2_q) begin
                        state_d = StData;
                        bcnt_d  = '0;
                    end
                end
                StData: begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    bcnt_d  = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    par_d   = dat_s2_q;
                    state_d = StStop;
                end
                StStop: begin
                    if (dat_s2_q && (^{shift_q, par_q})) begin
                        rx_valid_d = 1'b1;
                        rx_byte_d  = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Key tracker next-state, driven by the registered receive pulses
    always_comb begin
        scan_d = scan;
        prev_d = prevscan;
        ext_d  = ext_q;
        brk_d  = brk_q;
        if (frame_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == 8'hE0) begin
                ext_d = 1'b1;
            end else if (rx_byte == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (ext_q) begin
                    // Extended keys are not note keys
                end else if (brk_q) begin
                    if (rx_byte == scan)     scan_d = 8'h00;
                    if (rx_byte == prevscan) prev_d = 8'h00;
                end else if (rx_byte != scan) begin
                    scan_d = rx_byte;
                    // Re-pressing the previous key swaps slots instead of duplicating
                    if (rx_byte == prevscan || scan != 8'h00) prev_d = scan;
                end
            end
        end
    end

    // State registers for filter, frame FSM and key tracker
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q   <= 1'b1;
            fcnt_q    <= '0;
            state_q   <= StIdle;
            bcnt_q    <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            wdog_q    <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            scan      <= '0;
            prevscan  <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            level_q   <= level_d;
            fcnt_q    <= fcnt_d;
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            wdog_q    <= wdog_d;
            rx_byte   <= rx_byte_d;
            rx_valid  <= rx_valid_d;
            frame_err <= frame_err_d;
            scan      <= scan_d;
            prevscan  <= prev_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
        end
    end

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Self-checking bench for ps2_scan_rx: scripted scenarios plus random key traffic.
module tb_ps2_scan_rx;

    localparam int TMO = 2000;
    localparam int H   = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scan, prevscan, rx_byte;
    logic       rx_valid, frame_err;

    int n_vec = 0;
    int n_bad = 0;
    int cnt_valid = 0;
    int cnt_err = 0;
    int cnt_both = 0;

    // Reference model: held keys and prefix flags
    logic [7:0] m_scan = 8'h00, m_prev = 8'h00, m_byte = 8'h00;
    bit         m_ext = 1'b0, m_brk = 1'b0;
    int         m_nvalid = 0, m_nerr = 0;

    ps2_scan_rx #(.FILT_LEN(8), .TIMEOUT_CYC(TMO)) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .scan     (scan),
        .prevscan (prevscan),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (rx_valid) cnt_valid++;
        if (frame_err) cnt_err++;
        if (rx_valid && frame_err) cnt_both++;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_rx(input logic [7:0] b);
        logic [7:0] old;
        m_byte = b;
        m_nvalid++;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (m_ext) begin
            end else if (m_brk) begin
                if (b == m_scan) m_scan = 8'h00;
                if (b == m_prev) m_prev = 8'h00;
            end else if (b != m_scan) begin
                old    = m_scan;
                m_scan = b;
                if (b == m_prev) m_prev = old;
                else if (old != 8'h00) m_prev = old;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_err();
        m_nerr++;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    // Drive nbits of an 11-bit frame; optional parity flip and a short clock glitch
    task automatic drive_frame(input logic [7:0] b, input bit flip, input int nbits,
                               input int glitch_at);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_cyc(H / 2);
            if (i == glitch_at) begin
                ps2_clk = 1'b0;
                wait_cyc(2);
                ps2_clk = 1'b1;
            end
            wait_cyc(H / 2);
            ps2_clk = 1'b0;
            wait_cyc(H);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        wait_cyc(H);
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".nvalid"}, cnt_valid, m_nvalid);
        check_eq({tag, ".nerr"}, cnt_err, m_nerr);
        check_eq({tag, ".rx_byte"}, int'(rx_byte), int'(m_byte));
        check_eq({tag, ".scan"}, int'(scan), int'(m_scan));
        check_eq({tag, ".prevscan"}, int'(prevscan), int'(m_prev));
    endtask

    task automatic good(input logic [7:0] b, input string tag);
        drive_frame(b, 1'b0, 11, -1);
        model_rx(b);
        check_state(tag);
    endtask

    initial begin
        logic [7:0] pool [8];
        logic [7:0] b;
        int         k;
        pool = '{8'h12, 8'h2D, 8'h23, 8'h1B, 8'h3A, 8'hE0, 8'hF0, 8'h75};

        wait_cyc(3);
        check_eq("reset.scan", int'(scan), 0);
        check_eq("reset.prevscan", int'(prevscan), 0);
        check_eq("reset.rx_valid", int'(rx_valid), 0);
        reset = 1'b1;
        wait_cyc(20);

        good(8'h23, "t1");
        good(8'h12, "t2a");
        good(8'h2D, "t2b");
        good(8'hF0, "t2c");
        good(8'h2D, "t2d");
        good(8'h23, "t2e");
        for (int i = 0; i < 5; i++) good(8'h23, "t3");

        good(8'hF0, "t4pre");
        drive_frame(8'h3A, 1'b1, 11, -1);
        model_err();
        check_state("t4err");
        good(8'h23, "t4post");

        drive_frame(8'h55, 1'b0, 5, -1);
        wait_cyc(TMO + 50);
        model_err();
        check_state("t5tmo");
        good(8'h1B, "t5post");

        good(8'hE0, "t6a");
        good(8'h75, "t6b");
        drive_frame(8'h2D, 1'b0, 11, 4);
        model_rx(8'h2D);
        check_state("t6glitch");

        // Mid-frame reset with a pending break prefix
        good(8'hF0, "t6f0");
        drive_frame(8'h23, 1'b0, 4, -1);
        #3;
        reset = 1'b0;
        #1;
        check_eq("arst.scan", int'(scan), 0);
        check_eq("arst.prevscan", int'(prevscan), 0);
        check_eq("arst.rx_byte", int'(rx_byte), 0);
        check_eq("arst.pulses", int'({rx_valid, frame_err}), 0);
        m_scan = 8'h00; m_prev = 8'h00; m_byte = 8'h00; m_ext = 1'b0; m_brk = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(5);
        reset = 1'b1;
        wait_cyc(20);
        good(8'h2D, "t6after");

        // Random traffic: mostly good frames, some parity errors and glitches
        for (int i = 0; i < 40; i++) begin
            k = int'($urandom_range(0, 19));
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 8'hDF)) : pool[$urandom_range(0, 7)];
            if (k < 2) begin
                drive_frame(b, 1'b1, 11, -1);
                model_err();
                check_state("rnd_par");
            end else if (k < 4) begin
                drive_frame(b, 1'b0, 11, int'($urandom_range(1, 9)));
                model_rx(b);
                check_state("rnd_glitch");
            end else begin
                good(b, "rnd");
            end
        end

        check_eq("valid_err_overlap", cnt_both, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
